icache_rsp: RTL and testbench
=============================

# icache_rsp

Direct-mapped, read-only instruction cache answering the fetch stage's Icache request interface (ADR_SI / ADR_VALID_SI in, IC_INST_SI / IC_STALL_SI out). A hit returns the instruction combinationally in the request cycle. A miss holds IC_STALL_SI high while a two-state FSM refills the whole line from the memory port, one word per acknowledge. The block sits between the fetch stage and the instruction memory bus.

## Interface
Parameters:
- NUM_LINES, 16, number of cache lines (power of two, ≥2)
- LINE_WORDS, 4, 32-bit words per line (power of two, ≥2)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- ADR_SI  in  32  fetch byte address; bits [1:0] ignored
- ADR_VALID_SI  in  1  fetch request valid
- IC_INST_SI  out  32  instruction word; 32'h00000013 (nop) when not a hit
- IC_STALL_SI  out  1  high when a valid request cannot be served this cycle
- IC_FLUSH_SI  in  1  invalidate all lines (fence.i)
- MEM_ADR_SIC  out  32  word address requested from memory
- MEM_ADR_VALID_SIC  out  1  memory request valid
- MEM_ACK_SP  in  1  memory returns MEM_DATA_SP this cycle for MEM_ADR_SIC
- MEM_DATA_SP  in  32  memory read data

## Operation
- Address split:
  - offset = ADR_SI[log2(LINE_WORDS)+1:2]
  - index = next log2(NUM_LINES) bits
  - tag = remaining upper bits
- Storage:
  - data array NUM_LINES×LINE_WORDS×32
  - tag array
  - valid vector NUM_LINES bits
- hit = ADR_VALID_SI & state==IDLE & valid[index] & tag match.
- IC_INST_SI = data[index][offset] on hit, else 32'h13.
- IC_STALL_SI = ADR_VALID_SI & !hit. Always 0 when ADR_VALID_SI=0.
- FSM states:
  - IDLE:
    - On ADR_VALID_SI & !hit & !IC_FLUSH_SI: latch line base (ADR_SI with offset and [1:0] zeroed), clear word counter, enter REFILL.
  - REFILL:
    - MEM_ADR_VALID_SIC=1.
    - MEM_ADR_SIC = line base + 4·counter.
    - On MEM_ACK_SP: write MEM_DATA_SP to data[latched index][counter], counter+1.
    - On the ack of word LINE_WORDS-1: write the tag, set valid (unless flush_pending), clear flush_pending, return to IDLE.
- MEM_ADR_VALID_SIC=0 and MEM_ADR_SIC=0 in IDLE.
- Counter width is log2(LINE_WORDS). It wraps to 0 after the last word.
- Boundary rules:
  - ADR_VALID_SI dropping or ADR_SI changing during REFILL: refill runs to completion. The new address is looked up only after returning to IDLE.
  - IC_FLUSH_SI in IDLE: the valid vector is cleared at the edge. Lookup in the same cycle still uses the pre-flush valid bits, and no refill starts that cycle.
  - IC_FLUSH_SI in REFILL: the valid vector is cleared and flush_pending is set. The completing line is written but left invalid.
  - Refill into an occupied index overwrites it. The old line's valid bit is cleared on entry to REFILL.
  - Reset mid-refill: FSM returns to IDLE, all valid bits and flush_pending cleared, memory request dropped. Data and tag arrays are not reset.

## Timing
- Reset values:
  - state=IDLE, valid=0, counter=0, flush_pending=0
  - MEM_ADR_VALID_SIC=0, MEM_ADR_SIC=0
  - IC_STALL_SI=ADR_VALID_SI, IC_INST_SI=32'h13
- Hit latency: 0 cycles (combinational from ADR_SI).
- Miss, cycle by cycle:
  - Miss detected at cycle t.
  - REFILL from t+1, with MEM_ADR_VALID_SIC high starting t+1.
  - With a single-cycle ack per word, the last word is acked at t+LINE_WORDS.
  - IDLE at t+LINE_WORDS+1, and the same address hits in that cycle.
  - Minimum miss penalty: LINE_WORDS+1 stalled cycles.
- Memory handshake:
  - Request held stable until acked.
  - Any number of wait cycles (MEM_ACK_SP=0) is tolerated.
  - MEM_ACK_SP outside REFILL is ignored.
- IC_STALL_SI stays high through the final ack cycle.

## Test plan
- Reset, then ADR_SI=0x100 valid. Memory acks 0x11,0x22,0x33,0x44 on consecutive cycles.
  - Required: MEM_ADR_SIC steps 0x100,0x104,0x108,0x10C.
  - Required: stall for 5 cycles, then IC_INST_SI=0x11 with stall=0.
  - Then ADR_SI=0x108 → 0x33, same cycle, no stall.
- Conflict: after filling 0x100, request 0x200 (same index, NUM_LINES=16, LINE_WORDS=4).
  - Required: refill at 0x200..0x20C.
  - Required: 0x100 then misses again.
- Memory inserts 3 wait cycles before each ack.
  - Required: MEM_ADR_SIC is held during each wait.
  - Required: the stall lasts 4·4+1=17 cycles, and the data is correct.
- IC_FLUSH_SI pulsed while idle with line 0x100 valid.
  - Required: the next request to 0x100 misses and refetches.
- IC_FLUSH_SI pulsed during the 2nd word of a refill of 0x300.
  - Required: the refill completes, 0x300 still misses afterwards, and a new refill is issued.
- reset asserted during the 3rd word of a refill.
  - Required: MEM_ADR_VALID_SIC=0 the next cycle and state IDLE.
  - Required: a request to the same line issues a full 4-word refill from word 0.

Source files
------------

// File: rtl/icache_rsp.sv
// icache_rsp: direct-mapped read-only instruction cache with line refill FSM
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   ADR_SI              fetch byte address (bits [1:0] ignored)
//   ADR_VALID_SI        fetch request valid
//   IC_INST_SI          instruction on hit, nop (32'h13) otherwise
//   IC_STALL_SI         valid request that cannot be served this cycle
//   IC_FLUSH_SI         invalidate all lines (fence.i)
//   MEM_ADR_SIC         word address requested from memory during refill
//   MEM_ADR_VALID_SIC   memory request valid (high throughout refill)
//   MEM_ACK_SP          memory returns MEM_DATA_SP for MEM_ADR_SIC
//   MEM_DATA_SP         memory read data
module icache_rsp #(
    parameter int NUM_LINES  = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ADR_SI,
    input  logic        ADR_VALID_SI,
    output logic [31:0] IC_INST_SI,
    output logic        IC_STALL_SI,
    input  logic        IC_FLUSH_SI,
    output logic [31:0] MEM_ADR_SIC,
    output logic        MEM_ADR_VALID_SIC,
    input  logic        MEM_ACK_SP,
    input  logic [31:0] MEM_DATA_SP
);
    localparam int OW = $clog2(LINE_WORDS);
    localparam int IW = $clog2(NUM_LINES);
    localparam int TW = 32 - IW - OW - 2;
    typedef enum logic {IDLE, REFILL} state_t;
    state_t               state;
    logic [31:0]          data_mem [NUM_LINES*LINE_WORDS];
    logic [TW-1:0]        tag_mem [NUM_LINES];
    logic [NUM_LINES-1:0] valid;
    logic [OW-1:0]        cnt;
    logic [IW-1:0]        ref_idx;
    logic [TW-1:0]        ref_tag;
    logic                 flush_pending;
    logic [OW-1:0]        off;
    logic [IW-1:0]        idx;
    logic [TW-1:0]        tag;
    logic                 hit;
    logic                 ack;
    logic                 last;
    logic                 unused;
    assign off    = ADR_SI[OW+1:2];
    assign idx    = ADR_SI[OW+IW+1:OW+2];
    assign tag    = ADR_SI[31:OW+IW+2];
    assign unused = ^ADR_SI[1:0];
    assign hit  = ADR_VALID_SI && state == IDLE && valid[idx] && tag_mem[idx] == tag;
    assign ack  = state == REFILL && MEM_ACK_SP;
    assign last = &cnt;
    assign IC_INST_SI        = hit ? data_mem[{idx, off}] : 32'h00000013;
    assign IC_STALL_SI       = ADR_VALID_SI && !hit;
    assign MEM_ADR_VALID_SIC = state == REFILL;
    // line base plus word counter is just the counter spliced into the offset field
    assign MEM_ADR_SIC       = state == REFILL ? {ref_tag, ref_idx, cnt, 2'b00} : 32'h0;
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            valid         <= '0;
            cnt           <= '0;
            flush_pending <= 1'b0;
        end else if (state == IDLE) begin
            if (IC_FLUSH_SI)
                valid <= '0;
            else if (ADR_VALID_SI && !hit) begin
                ref_idx    <= idx;
                ref_tag    <= tag;
                cnt        <= '0;
                valid[idx] <= 1'b0;
                state      <= REFILL;
            end
        end else begin
            if (ack) begin
                cnt <= cnt + 1'b1;
                if (last) begin
                    state         <= IDLE;
                    flush_pending <= 1'b0;
                    if (!flush_pending)
                        valid[ref_idx] <= 1'b1;
                end
            end
            // a flush overrides the completing line's valid bit via the later assignment
            if (IC_FLUSH_SI) begin
                valid <= '0;
                if (!(ack && last))
                    flush_pending <= 1'b1;
            end
        end
    end
    // arrays carry no reset so they can map onto plain RAM
    always_ff @(posedge clk) begin
        if (!reset && ack) begin
            data_mem[{ref_idx, cnt}] <= MEM_DATA_SP;
            if (last)
                tag_mem[ref_idx] <= ref_tag;
        end
    end
endmodule

// File: tb/tb_icache_rsp.sv
// tb_icache_rsp: directed self-checking bench for icache_rsp (16 lines x 4 words)
//
// Drives fetch requests and plays the memory side; each scenario task checks
// its own observations against hand-computed values.
module tb_icache_rsp;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ADR_SI;
    logic        ADR_VALID_SI;
    logic [31:0] IC_INST_SI;
    logic        IC_STALL_SI;
    logic        IC_FLUSH_SI;
    logic [31:0] MEM_ADR_SIC;
    logic        MEM_ADR_VALID_SIC;
    logic        MEM_ACK_SP;
    logic [31:0] MEM_DATA_SP;
    int total = 0;
    int bad   = 0;

    icache_rsp #(.NUM_LINES(16), .LINE_WORDS(4)) dut (
        .clk(clk), .reset(reset), .ADR_SI(ADR_SI), .ADR_VALID_SI(ADR_VALID_SI),
        .IC_INST_SI(IC_INST_SI), .IC_STALL_SI(IC_STALL_SI), .IC_FLUSH_SI(IC_FLUSH_SI),
        .MEM_ADR_SIC(MEM_ADR_SIC), .MEM_ADR_VALID_SIC(MEM_ADR_VALID_SIC),
        .MEM_ACK_SP(MEM_ACK_SP), .MEM_DATA_SP(MEM_DATA_SP)
    );

    always #5 clk = ~clk;

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    // Plays memory for one line: waits cycles of no-ack before each ack, records the
    // address of each word, counts stalled cycles from the current (request) cycle.
    // Returns when the stall drops, or right after the line completes into IDLE.
    task automatic serve(input int waits, input int flush_k,
                         input logic [31:0] d0, d1, d2, d3,
                         output logic [31:0] a [4], output int stalls, output bit held);
        logic [31:0] d [4];
        int w = 0;
        int k = 0;
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
        for (int i = 0; i < 4; i++) a[i] = 32'hdead_beef;
        stalls = 0;
        held   = 1'b1;
        for (int c = 0; c <= 200; c++) begin
            if (c == 200) begin
                stalls = -1;
                break;
            end
            #1;
            if (!IC_STALL_SI) break;
            if (k == 4 && !MEM_ADR_VALID_SIC) break;
            stalls++;
            if (MEM_ADR_VALID_SIC && k < 4) begin
                if (w == 0) a[k] = MEM_ADR_SIC;
                else if (MEM_ADR_SIC !== a[k]) held = 1'b0;
                if (w == 0 && k == flush_k) IC_FLUSH_SI = 1'b1;
                if (w == waits) begin
                    MEM_ACK_SP  = 1'b1;
                    MEM_DATA_SP = d[k];
                    k++;
                    w = 0;
                end else
                    w++;
            end
            @(posedge clk);
            #1;
            MEM_ACK_SP  = 1'b0;
            IC_FLUSH_SI = 1'b0;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; ADR_SI = 32'h100; ADR_VALID_SI = 1'b1; IC_FLUSH_SI = 1'b0;
        MEM_ACK_SP = 1'b0; MEM_DATA_SP = 32'h0;
        cyc; cyc;
        total++; if (IC_STALL_SI !== 1'b1) begin bad++; $display("FAIL reset_stall got=%b exp=1", IC_STALL_SI); end
        total++; if (IC_INST_SI !== 32'h13) begin bad++; $display("FAIL reset_inst got=%h exp=00000013", IC_INST_SI); end
        total++; if (MEM_ADR_VALID_SIC !== 1'b0 || MEM_ADR_SIC !== 32'h0) begin bad++;
            $display("FAIL reset_mem got=%b/%h exp=0/00000000", MEM_ADR_VALID_SIC, MEM_ADR_SIC); end
        ADR_VALID_SI = 1'b0;
        #1;
        total++; if (IC_STALL_SI !== 1'b0) begin bad++; $display("FAIL reset_nostall got=%b exp=0", IC_STALL_SI); end
        reset = 1'b0;
        cyc;
    endtask

    task automatic test_miss_refill;
        logic [31:0] a [4];
        int st;
        bit h;
        ADR_SI = 32'h100; ADR_VALID_SI = 1'b1;
        serve(0, -1, 32'h11, 32'h22, 32'h33, 32'h44, a, st, h);
        total++; if (a[0] !== 32'h100 || a[1] !== 32'h104 || a[2] !== 32'h108 || a[3] !== 32'h10c) begin bad++;
            $display("FAIL miss_adr got=%h %h %h %h exp=100 104 108 10c", a[0], a[1], a[2], a[3]); end
        total++; if (st !== 5) begin bad++; $display("FAIL miss_stalls got=%0d exp=5", st); end
        total++; if (IC_INST_SI !== 32'h11) begin bad++; $display("FAIL miss_inst got=%h exp=00000011", IC_INST_SI); end
        ADR_SI = 32'h108;
        #1;
        total++; if (IC_INST_SI !== 32'h33 || IC_STALL_SI !== 1'b0) begin bad++;
            $display("FAIL hit_108 got=%h/%b exp=00000033/0", IC_INST_SI, IC_STALL_SI); end
        ADR_VALID_SI = 1'b0;
        #1;
        total++; if (IC_INST_SI !== 32'h13 || IC_STALL_SI !== 1'b0) begin bad++;
            $display("FAIL novalid got=%h/%b exp=00000013/0", IC_INST_SI, IC_STALL_SI); end
        cyc;
    endtask

    task automatic test_conflict;
        logic [31:0] a [4];
        int st;
        bit h;
        ADR_SI = 32'h200; ADR_VALID_SI = 1'b1;
        serve(0, -1, 32'ha1, 32'ha2, 32'ha3, 32'ha4, a, st, h);
        total++; if (a[0] !== 32'h200 || a[3] !== 32'h20c || st !== 5) begin bad++;
            $display("FAIL conflict_refill got=%h..%h st=%0d exp=200..20c st=5", a[0], a[3], st); end
        total++; if (IC_INST_SI !== 32'ha1) begin bad++; $display("FAIL conflict_inst got=%h exp=000000a1", IC_INST_SI); end
        ADR_SI = 32'h100;
        #1;
        total++; if (IC_STALL_SI !== 1'b1) begin bad++; $display("FAIL conflict_evict got=%b exp=1", IC_STALL_SI); end
        ADR_VALID_SI = 1'b0;
        cyc;
    endtask

    task automatic test_wait_states;
        logic [31:0] a [4];
        int st;
        bit h;
        ADR_SI = 32'h100; ADR_VALID_SI = 1'b1;
        serve(3, -1, 32'h11, 32'h22, 32'h33, 32'h44, a, st, h);
        total++; if (!h) begin bad++; $display("FAIL wait_held got=unstable exp=stable"); end
        total++; if (a[0] !== 32'h100 || a[3] !== 32'h10c) begin bad++;
            $display("FAIL wait_adr got=%h..%h exp=100..10c", a[0], a[3]); end
        total++; if (st !== 17) begin bad++; $display("FAIL wait_stalls got=%0d exp=17", st); end
        total++; if (IC_INST_SI !== 32'h11) begin bad++; $display("FAIL wait_inst got=%h exp=00000011", IC_INST_SI); end
    endtask

    task automatic test_flush_idle;
        logic [31:0] a [4];
        int st;
        bit h;
        ADR_SI = 32'h104; IC_FLUSH_SI = 1'b1;
        #1;
        total++; if (IC_INST_SI !== 32'h22 || IC_STALL_SI !== 1'b0) begin bad++;
            $display("FAIL flush_prehit got=%h/%b exp=00000022/0", IC_INST_SI, IC_STALL_SI); end
        cyc;
        total++; if (IC_STALL_SI !== 1'b1) begin bad++; $display("FAIL flush_cleared got=%b exp=1", IC_STALL_SI); end
        cyc;
        IC_FLUSH_SI = 1'b0;
        total++; if (MEM_ADR_VALID_SIC !== 1'b0) begin bad++; $display("FAIL flush_norefill got=%b exp=0", MEM_ADR_VALID_SIC); end
        serve(0, -1, 32'h55, 32'h66, 32'h77, 32'h88, a, st, h);
        total++; if (a[0] !== 32'h100 || st !== 5 || IC_INST_SI !== 32'h66) begin bad++;
            $display("FAIL flush_refetch got=%h st=%0d inst=%h exp=100 st=5 inst=00000066", a[0], st, IC_INST_SI); end
        ADR_VALID_SI = 1'b0;
        cyc;
    endtask

    task automatic test_flush_refill;
        logic [31:0] a [4];
        int st;
        bit h;
        ADR_SI = 32'h300; ADR_VALID_SI = 1'b1;
        serve(0, 1, 32'hb1, 32'hb2, 32'hb3, 32'hb4, a, st, h);
        total++; if (st !== 5 || a[3] !== 32'h30c) begin bad++; $display("FAIL flushref_done got=st%0d %h exp=st5 30c", st, a[3]); end
        total++; if (IC_STALL_SI !== 1'b1 || MEM_ADR_VALID_SIC !== 1'b0) begin bad++;
            $display("FAIL flushref_miss got=%b/%b exp=1/0", IC_STALL_SI, MEM_ADR_VALID_SIC); end
        cyc;
        total++; if (MEM_ADR_VALID_SIC !== 1'b1 || MEM_ADR_SIC !== 32'h300) begin bad++;
            $display("FAIL flushref_reissue got=%b/%h exp=1/00000300", MEM_ADR_VALID_SIC, MEM_ADR_SIC); end
        serve(0, -1, 32'hc1, 32'hc2, 32'hc3, 32'hc4, a, st, h);
        total++; if (st !== 4 || IC_INST_SI !== 32'hc1) begin bad++;
            $display("FAIL flushref_final got=st%0d %h exp=st4 000000c1", st, IC_INST_SI); end
        ADR_VALID_SI = 1'b0;
        cyc;
    endtask

    task automatic test_reset_mid;
        logic [31:0] a [4];
        int st;
        bit h;
        ADR_SI = 32'h400; ADR_VALID_SI = 1'b1;
        cyc;
        MEM_ACK_SP = 1'b1; MEM_DATA_SP = 32'hd1;
        cyc;
        MEM_DATA_SP = 32'hd2;
        cyc;
        MEM_ACK_SP = 1'b0;
        total++; if (MEM_ADR_SIC !== 32'h408) begin bad++; $display("FAIL rst_word2 got=%h exp=00000408", MEM_ADR_SIC); end
        reset = 1'b1; ADR_VALID_SI = 1'b0;
        cyc;
        total++; if (MEM_ADR_VALID_SIC !== 1'b0 || MEM_ADR_SIC !== 32'h0) begin bad++;
            $display("FAIL rst_drop got=%b/%h exp=0/00000000", MEM_ADR_VALID_SIC, MEM_ADR_SIC); end
        reset = 1'b0; ADR_VALID_SI = 1'b1;
        #1;
        total++; if (IC_STALL_SI !== 1'b1) begin bad++; $display("FAIL rst_miss got=%b exp=1", IC_STALL_SI); end
        serve(0, -1, 32'he1, 32'he2, 32'he3, 32'he4, a, st, h);
        total++; if (a[0] !== 32'h400 || a[3] !== 32'h40c || st !== 5 || IC_INST_SI !== 32'he1) begin bad++;
            $display("FAIL rst_refill got=%h..%h st=%0d inst=%h exp=400..40c st=5 inst=000000e1", a[0], a[3], st, IC_INST_SI); end
        ADR_VALID_SI = 1'b0;
        cyc;
    endtask

    initial begin
        test_reset;
        test_miss_refill;
        test_conflict;
        test_wait_states;
        test_flush_idle;
        test_flush_refill;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
